crp16_flag_unit: RTL and testbench
==================================

# crp16_flag_unit

Status-flag register and condition evaluator for the CRP16 core, sitting downstream of the ALU. It captures the ALU's V/C/N/Z outputs on command and answers registered condition-code queries for branch and conditional-execution logic. It also keeps a small LIFO of saved flag sets, so the interrupt entry/return path can preserve and restore status.

## Interface
- STACK_DEPTH, 4: number of saved flag sets, from 2 to 16.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alu_v, alu_c, alu_n, alu_z  in  1 each  ALU overflow, carry, negative and zero flags.
- flag_we  in  1  load all four ALU flags into the flag register.
- push  in  1  save the current flag register onto the stack.
- pop  in  1  restore the flag register from the top of the stack.
- err_clear  in  1  clear stack_err.
- cond_req  in  1  condition query strobe.
- cond  in  4  condition code for the query.
- flags  out  4  {V,C,N,Z} register.
- cond_valid  out  1  response strobe, one cycle after cond_req.
- cond_true  out  1  condition result; meaningful only while cond_valid=1.
- stack_count  out  $clog2(STACK_DEPTH+1)  number of occupied stack entries.
- stack_err  out  1  sticky overflow/underflow indicator.

## Operation
- **Flag write.** flag_we=1 writes {alu_v,alu_c,alu_n,alu_z} into flags, all four bits unconditionally.
  - Logic and shift operations drive C=V=0, and those zeros are stored.
  - C after a subtraction means "no borrow" (x >= y unsigned).
- **Push.**
  - Not full: stores the pre-write flags value at index stack_count, then increments stack_count.
  - Full: the push is ignored and stack_err is set.
- **Pop.**
  - Not empty: loads flags from entry stack_count-1, then decrements stack_count. The restore overrides a same-cycle flag_we.
  - Empty: the pop is ignored, stack_err is set, and a same-cycle flag_we still applies.
- **push and pop together.**
  - Neither stack operation is performed and stack_err is set.
  - flag_we applies normally.
- **push and flag_we together.** The old flags are saved and the new ALU flags are loaded.
- **stack_err.**
  - Sticky; cleared only by err_clear or reset.
  - If err_clear and a new error occur in the same cycle, the error wins and stack_err stays 1.
- **Condition query.** cond is evaluated against the next-state flags, i.e. after that cycle's flag_we/pop has taken effect. The result is registered.
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C & !Z
  - 9 LS: !C | Z
  - 10 GE: N == V
  - 11 LT: N != V
  - 12 GT: !Z & (N == V)
  - 13 LE: Z | (N != V)
  - 14 AL: 1
  - 15 NV: 0
- **Stack RAM.** Stack entries are not reset. Only stack_count determines which entries are valid.

## Timing
- **Reset values.** flags=0, stack_count=0, stack_err=0, cond_valid=0, cond_true=0.
- **Reset mid-operation.** Asserting reset_n low mid-operation immediately zeroes the outputs above and discards the stack contents and any in-flight query.
- **Update timing.**
  - flag_we, push and pop update flags and stack_count at the edge that samples them.
  - flags is visible the following cycle.
- **Query latency.**
  - cond_req sampled at edge k produces cond_valid=1 and cond_true during cycle k+1, for exactly one cycle.
  - Back-to-back queries give back-to-back responses, with no stall and no ready signal.
- **Queries with no request.** cond_valid=0 in cycles with no request. cond_true holds its last value.
- **Outputs.** All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- **Reset.** Drive reset_n=0 mid-stream with count=3 and pending cond_req -> all outputs 0 immediately. After release, cond_valid stays 0 until a new request.
- **Overflow.** ALU 0x7FFF+0x0001 gives V=1, N=1, C=0, Z=0. flag_we plus cond_req with GE(10) -> next cycle flags=4'b1010, cond_valid=1, cond_true=1. LT(11) -> cond_true=0.
- **Subtract with forwarding.** ALU 5-3 gives C=1, Z=0. Same-cycle flag_we and cond_req HI(8) -> cond_true=1, which checks forwarding. Then ALU 3-3 gives C=1, Z=1 -> HI=0, LS=1, EQ=1.
- **Stack overflow.** STACK_DEPTH=4: push four distinct flag sets -> stack_count=4, stack_err=0. A fifth push -> stack_count stays 4, stack_err=1. err_clear -> stack_err=0.
- **Pop sequence.** Four pops -> flags restored in reverse order (LIFO) and stack_count=0. A fifth pop -> stack_err=1, flags unchanged. Then pop with flag_we on an empty stack -> the ALU flags load.
- **Simultaneous events.**
  - pop+flag_we with count=1 -> the popped value wins.
  - push+pop -> count unchanged and stack_err=1.
  - push+flag_we -> the old value is saved and the new value is loaded. A subsequent pop returns the old value.

Source files
------------

// File: rtl/crp16_flag_unit_if.sv
// CRP16 flag unit bus: ALU flag inputs, stack/query commands and the
// registered status outputs. The master drives commands; the flag unit is
// the slave.
interface crp16_flag_unit_if #(
  parameter int STACK_DEPTH = 4
) ();
  localparam int CW = $clog2(STACK_DEPTH + 1);

  logic          alu_v;
  logic          alu_c;
  logic          alu_n;
  logic          alu_z;
  logic          flag_we;
  logic          push;
  logic          pop;
  logic          err_clear;
  logic          cond_req;
  logic [3:0]    cond;
  logic [3:0]    flags;
  logic          cond_valid;
  logic          cond_true;
  logic [CW-1:0] stack_count;
  logic          stack_err;

  modport master (
    output alu_v, alu_c, alu_n, alu_z, flag_we, push, pop, err_clear,
           cond_req, cond,
    input  flags, cond_valid, cond_true, stack_count, stack_err
  );

  modport slave (
    input  alu_v, alu_c, alu_n, alu_z, flag_we, push, pop, err_clear,
           cond_req, cond,
    output flags, cond_valid, cond_true, stack_count, stack_err
  );
endinterface

// File: rtl/crp16_flag_unit.sv
// CRP16 status-flag register with a small LIFO of saved flag sets and a
// registered condition-code evaluator. Queries see the flags as they will be
// after this cycle's write/restore, so a branch can test freshly computed flags.
module crp16_flag_unit #(
  parameter int STACK_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  crp16_flag_unit_if.slave   bus
);
  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  // Flag layout is {V,C,N,Z}.
  logic [3:0]    flags_reg, flags_next;
  logic [CW-1:0] count_reg, count_next;
  logic          err_reg, err_next;
  logic          valid_reg;
  logic          true_reg, true_next;

  // Stack storage carries no reset; stack_count alone marks valid entries.
  logic [3:0]    stack_mem [STACK_DEPTH];

  logic          full, empty;
  logic          do_push, do_pop, err_new;
  logic [IW-1:0] wr_idx, top_idx;
  logic [3:0]    pop_data;
  logic [3:0]    alu_flags;

  assign alu_flags = {bus.alu_v, bus.alu_c, bus.alu_n, bus.alu_z};
  assign full      = (count_reg == CW'(STACK_DEPTH));
  assign empty     = (count_reg == '0);

  // Push and pop together cancel each other and count as a stack error.
  assign do_push = bus.push & ~bus.pop & ~full;
  assign do_pop  = bus.pop & ~bus.push & ~empty;
  assign err_new = (bus.push & bus.pop)
                 | (bus.push & ~bus.pop & full)
                 | (bus.pop & ~bus.push & empty);

  assign wr_idx   = IW'(count_reg);
  assign top_idx  = IW'(count_reg - CW'(1));
  assign pop_data = stack_mem[top_idx];

  // Condition table: codes come in complementary pairs (even code, odd =
  // its negation), including AL/NV, so only eight base terms are needed.
  logic [7:0]  cond_base;
  logic [15:0] cond_vec;

  assign cond_base[0] = flags_next[0];                                   // EQ
  assign cond_base[1] = flags_next[2];                                   // CS
  assign cond_base[2] = flags_next[1];                                   // MI
  assign cond_base[3] = flags_next[3];                                   // VS
  assign cond_base[4] = flags_next[2] & ~flags_next[0];                  // HI
  assign cond_base[5] = (flags_next[1] == flags_next[3]);                // GE
  assign cond_base[6] = ~flags_next[0] & (flags_next[1] == flags_next[3]); // GT
  assign cond_base[7] = 1'b1;                                            // AL

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_cond_pair
      assign cond_vec[2*gi]   = cond_base[gi];
      assign cond_vec[2*gi+1] = ~cond_base[gi];
    end
  endgenerate

  // Next-state: a restore from the stack overrides an ALU flag write.
  always_comb begin
    flags_next = flags_reg;
    count_next = count_reg;
    err_next   = err_reg;
    true_next  = true_reg;
    if (do_pop) begin
      flags_next = pop_data;
      count_next = count_reg - CW'(1);
    end else if (bus.flag_we) begin
      flags_next = alu_flags;
    end
    if (do_push) begin
      count_next = count_reg + CW'(1);
    end
    if (err_new) begin
      err_next = 1'b1;
    end else if (bus.err_clear) begin
      err_next = 1'b0;
    end
    if (bus.cond_req) begin
      true_next = cond_vec[bus.cond];
    end
  end

  // Status registers and query response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flags_reg <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
      valid_reg <= 1'b0;
      true_reg  <= 1'b0;
    end else begin
      flags_reg <= flags_next;
      count_reg <= count_next;
      err_reg   <= err_next;
      valid_reg <= bus.cond_req;
      true_reg  <= true_next;
    end
  end

  // Save the pre-write flags on push.
  always_ff @(posedge clock) begin
    if (do_push) begin
      stack_mem[wr_idx] <= flags_reg;
    end
  end

  assign bus.flags       = flags_reg;
  assign bus.stack_count = count_reg;
  assign bus.stack_err   = err_reg;
  assign bus.cond_valid  = valid_reg;
  assign bus.cond_true   = true_reg;
endmodule

// File: tb/tb_crp16_flag_unit.sv
// Directed bench for crp16_flag_unit: query results go through a scoreboard
// queue, register state is checked after every step.
module tb_crp16_flag_unit;
  logic clock;
  logic reset_n;
  int   tests;
  int   fails;
  logic cond_exp;
  logic exp_q[$];

  crp16_flag_unit_if #(.STACK_DEPTH(4)) bus ();

  crp16_flag_unit #(.STACK_DEPTH(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic exp_cond(input logic [3:0] c, input logic [3:0] f);
    logic v, cy, n, z;
    {v, cy, n, z} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_alu(input logic [3:0] f);
    {bus.alu_v, bus.alu_c, bus.alu_n, bus.alu_z} = f;
  endtask

  task automatic query(input logic [3:0] c, input logic e);
    bus.cond_req = 1'b1;
    bus.cond     = c;
    cond_exp     = e;
  endtask

  // One clock: record expected response, clock, clear strobes, score output.
  task automatic cycle();
    logic e;
    if (bus.cond_req) exp_q.push_back(cond_exp);
    @(posedge clock);
    #1;
    bus.flag_we   = 1'b0;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.err_clear = 1'b0;
    bus.cond_req  = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cond_valid", 8'(bus.cond_valid), 8'd1);
      chk("cond_true", 8'(bus.cond_true), 8'(e));
    end else begin
      chk("cond_valid_idle", 8'(bus.cond_valid), 8'd0);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] f, input int cnt, input logic err);
    chk({tag, "_flags"}, 8'(bus.flags), 8'(f));
    chk({tag, "_count"}, 8'(bus.stack_count), 8'(cnt));
    chk({tag, "_err"}, 8'(bus.stack_err), 8'(err));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cond_exp = 1'b0;
    reset_n = 1'b0;
    bus.alu_v = 0; bus.alu_c = 0; bus.alu_n = 0; bus.alu_z = 0;
    bus.flag_we = 0; bus.push = 0; bus.pop = 0; bus.err_clear = 0;
    bus.cond_req = 0; bus.cond = 4'd0;

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    chk_state("reset", 4'b0000, 0, 1'b0);
    chk("reset_valid", 8'(bus.cond_valid), 8'd0);
    chk("reset_true", 8'(bus.cond_true), 8'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cycle();

    // Overflow: 0x7FFF + 1 -> V=1 N=1
    set_alu(4'b1010); bus.flag_we = 1; query(4'd10, 1'b1); cycle();
    chk_state("ovf", 4'b1010, 0, 1'b0);
    query(4'd11, 1'b0); cycle();

    // Subtract 5-3 with same-cycle query, then 3-3
    set_alu(4'b0100); bus.flag_we = 1; query(4'd8, 1'b1); cycle();
    chk_state("sub53", 4'b0100, 0, 1'b0);
    set_alu(4'b0101); bus.flag_we = 1; query(4'd8, 1'b0); cycle();
    query(4'd9, 1'b1); cycle();
    query(4'd0, 1'b1); cycle();
    chk_state("sub33", 4'b0101, 0, 1'b0);

    // Fill the stack with four distinct sets (push+flag_we saves old value)
    set_alu(4'b0001); bus.flag_we = 1; cycle();
    set_alu(4'b0010); bus.flag_we = 1; bus.push = 1; cycle();
    chk_state("push1", 4'b0010, 1, 1'b0);
    set_alu(4'b0100); bus.flag_we = 1; bus.push = 1; cycle();
    chk_state("push2", 4'b0100, 2, 1'b0);
    set_alu(4'b1000); bus.flag_we = 1; bus.push = 1; cycle();
    chk_state("push3", 4'b1000, 3, 1'b0);
    bus.push = 1; cycle();
    chk_state("push4", 4'b1000, 4, 1'b0);
    bus.push = 1; cycle();
    chk_state("push_full", 4'b1000, 4, 1'b1);
    bus.err_clear = 1; cycle();
    chk_state("clr1", 4'b1000, 4, 1'b0);

    // Pops in LIFO order; queries see the restored value
    bus.pop = 1; query(4'd0, 1'b0); cycle();
    chk_state("pop1", 4'b1000, 3, 1'b0);
    bus.pop = 1; query(4'd2, 1'b1); cycle();
    chk_state("pop2", 4'b0100, 2, 1'b0);
    bus.pop = 1; cycle();
    chk_state("pop3", 4'b0010, 1, 1'b0);
    set_alu(4'b1111); bus.flag_we = 1; bus.pop = 1; cycle();
    chk_state("pop4_we", 4'b0001, 0, 1'b0);
    bus.pop = 1; cycle();
    chk_state("pop_empty", 4'b0001, 0, 1'b1);
    bus.err_clear = 1; cycle();
    chk_state("clr2", 4'b0001, 0, 1'b0);
    set_alu(4'b0110); bus.flag_we = 1; bus.pop = 1; bus.err_clear = 1; cycle();
    chk_state("pop_empty_we", 4'b0110, 0, 1'b1);

    // push+pop cancels, flag_we still applies
    bus.err_clear = 1; cycle();
    bus.push = 1; cycle();
    chk_state("push_a", 4'b0110, 1, 1'b0);
    set_alu(4'b0011); bus.flag_we = 1; bus.push = 1; bus.pop = 1; cycle();
    chk_state("pushpop", 4'b0011, 1, 1'b1);
    bus.pop = 1; cycle();
    chk_state("pop_a", 4'b0110, 0, 1'b1);
    set_alu(4'b1001); bus.flag_we = 1; bus.push = 1; cycle();
    chk_state("push_we", 4'b1001, 1, 1'b1);
    bus.pop = 1; cycle();
    chk_state("pop_old", 4'b0110, 0, 1'b1);

    // All sixteen conditions back-to-back against V0 C1 N1 Z0
    for (int c = 0; c < 16; c++) begin
      query(4'(c), exp_cond(4'(c), 4'b0110));
      cycle();
    end
    query(4'd14, 1'b1); cycle();
    cycle();
    chk("true_hold", 8'(bus.cond_true), 8'd1);

    // Reset mid-stream with three entries and a pending query
    repeat (3) begin
      bus.push = 1; cycle();
    end
    chk_state("pre_rst", 4'b0110, 3, 1'b1);
    query(4'd14, 1'b1); cycle();
    bus.cond_req = 1'b1;
    bus.cond = 4'd14;
    #2;
    reset_n = 1'b0;
    #1;
    chk_state("async_rst", 4'b0000, 0, 1'b0);
    chk("async_rst_valid", 8'(bus.cond_valid), 8'd0);
    chk("async_rst_true", 8'(bus.cond_true), 8'd0);
    @(negedge clock);
    bus.cond_req = 1'b0;
    exp_q.delete();
    reset_n = 1'b1;
    cycle();
    cycle();
    chk_state("post_rst", 4'b0000, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
